// File: rtl/scan_chain_rx_if.sv
// Scan-chain bundle between the hop controller (master) and the chip-side receiver (slave).
// The interface carries the five scan inputs into the receiver and its capture results back out.
interface scan_chain_rx_if #(
   parameter int NBITS = 64
);
   localparam int NW = $clog2(NBITS) + 1;

   logic             scan_id;
   logic             scan_phi;
   logic             scan_phi_bar;
   logic             scan_data_in;
   logic             scan_load_chip;
   logic [NBITS-1:0] data_out;
   logic             data_valid;
   logic [NW-1:0]    nbits_rx;
   logic             frame_err;
   logic             proto_err;
   logic             scan_data_out;

   modport master (
      output scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip,
      input  data_out, data_valid, nbits_rx, frame_err, proto_err, scan_data_out
   );

   modport slave (
      input  scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip,
      output data_out, data_valid, nbits_rx, frame_err, proto_err, scan_data_out
   );
endinterface

// File: rtl/scan_chain_rx.sv
// Chip-side two-phase scan-chain receiver: oversamples the scan pins on clk, shifts the
// serial stream into an NBITS chain and transfers it to a parallel word on a load strobe.
module scan_chain_rx #(
   parameter int NBITS       = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           reset,
   scan_chain_rx_if.slave bus
);
   localparam int NW = $clog2(NBITS) + 1;

   localparam int ID  = 0;
   localparam int PHI = 1;
   localparam int PHB = 2;
   localparam int DIN = 3;
   localparam int LD  = 4;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      CAPTURED
   } state_e;

   logic [4:0]                    raw;
   logic [SYNC_STAGES-1:0][4:0]   sync_q;
   logic [4:0]                    s;
   logic [2:0]                    dly_q;   // {load, phi_bar, phi} from the previous cycle

   logic id_s, phi_s, phb_s, din_s;
   logic phi_rise, phb_rise, ld_rise;

   state_e           state_q, state_d;
   logic             master_q, master_d;
   logic [NBITS-1:0] shift_q, shift_d;
   logic [NBITS-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic [NW-1:0]    nbits_q, nbits_d;
   logic             ferr_q, ferr_d;
   logic             perr_q, perr_d;

   assign raw = {bus.scan_load_chip, bus.scan_data_in, bus.scan_phi_bar,
                 bus.scan_phi, bus.scan_id};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         dly_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         dly_q  <= {s[LD], s[PHB], s[PHI]};
      end
   end

   assign s        = sync_q[SYNC_STAGES-1];
   assign id_s     = s[ID];
   assign phi_s    = s[PHI];
   assign phb_s    = s[PHB];
   assign din_s    = s[DIN];
   assign phi_rise = s[PHI] & ~dly_q[0];
   assign phb_rise = s[PHB] & ~dly_q[1];
   assign ld_rise  = s[LD]  & ~dly_q[2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         master_q <= 1'b0;
         shift_q  <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         nbits_q  <= '0;
         ferr_q   <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         master_q <= master_d;
         shift_q  <= shift_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         nbits_q  <= nbits_d;
         ferr_q   <= ferr_d;
         perr_q   <= perr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      master_d = master_q;
      shift_d  = shift_q;
      dout_d   = dout_q;
      valid_d  = 1'b0;
      nbits_d  = nbits_q;
      ferr_d   = ferr_q;
      perr_d   = perr_q;

      if (!id_s) begin
         state_d = IDLE;
         nbits_d = '0;
      end else if (state_q == IDLE) begin
         state_d = ARMED;
      end else begin
         // Overlapping phases flag an error and swallow any edge seen in the same cycle.
         if (phi_s && phb_s) begin
            perr_d = 1'b1;
         end else begin
            if (phi_rise) begin
               master_d = din_s;
               state_d  = CAPTURED;
            end
            if (phb_rise) begin
               if (state_q == CAPTURED) begin
                  shift_d = {shift_q[NBITS-2:0], master_q};
                  if (nbits_q != '1) nbits_d = nbits_q + 1'b1;
                  state_d = ARMED;
               end else begin
                  perr_d = 1'b1;
               end
            end
         end

         // Load sees the post-shift chain and count when both land in one cycle.
         if (ld_rise) begin
            dout_d  = shift_d;
            valid_d = 1'b1;
            ferr_d  = (nbits_d != NW'(NBITS));
            nbits_d = '0;
            perr_d  = 1'b0;
            state_d = ARMED;
         end
      end
   end

   assign bus.data_out      = dout_q;
   assign bus.data_valid    = valid_q;
   assign bus.nbits_rx      = nbits_q;
   assign bus.frame_err     = ferr_q;
   assign bus.proto_err     = perr_q;
   assign bus.scan_data_out = shift_q[NBITS-1];

endmodule

// File: tb/tb_scan_chain_rx.sv
// Directed bench for scan_chain_rx: drives the two-phase protocol through the interface
// and checks captured words, counters and error flags against a shift-register model.
`timescale 1ns/1ps
module tb_scan_chain_rx;
   localparam int NBITS = 64;
   localparam int NW    = $clog2(NBITS) + 1;

   logic clk;
   logic reset;
   int   nerr;
   int   nchk;
   int   vcount;
   int   v0;
   logic [63:0] sh;
   logic [63:0] prev;

   scan_chain_rx_if #(.NBITS(NBITS)) bus ();

   scan_chain_rx #(.NBITS(NBITS), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (bus.data_valid === 1'b1) vcount++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach the end, got timeout required finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      bus.scan_data_in = b;
      tick(3);
      bus.scan_phi = 1'b1;
      tick(3);
      bus.scan_phi = 1'b0;
      tick(3);
      bus.scan_phi_bar = 1'b1;
      tick(3);
      bus.scan_phi_bar = 1'b0;
      tick(3);
   endtask

   task automatic send_word(input logic [63:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic load_pulse();
      bus.scan_load_chip = 1'b1;
      tick(4);
      bus.scan_load_chip = 1'b0;
      tick(4);
   endtask

   initial begin
      nerr = 0; nchk = 0; vcount = 0;
      reset = 1'b1;
      bus.scan_id = 1'b0; bus.scan_phi = 1'b0; bus.scan_phi_bar = 1'b0;
      bus.scan_data_in = 1'b0; bus.scan_load_chip = 1'b0;
      tick(3);
      check("rst_data_out",  bus.data_out, 64'h0);
      check("rst_valid",     64'(bus.data_valid), 64'h0);
      check("rst_nbits",     64'(bus.nbits_rx), 64'h0);
      check("rst_frame_err", 64'(bus.frame_err), 64'h0);
      check("rst_proto_err", 64'(bus.proto_err), 64'h0);
      check("rst_sdo",       64'(bus.scan_data_out), 64'h0);
      reset = 1'b0;
      tick(2);

      // Full 64-bit frame
      bus.scan_id = 1'b1;
      tick(4);
      sh = 64'h02AAAAAAAAAAAAAA;
      send_word(sh, 64);
      check("full_nbits_pre", 64'(bus.nbits_rx), 64'd64);
      v0 = vcount;
      load_pulse();
      check("full_data_out",  bus.data_out, 64'h02AAAAAAAAAAAAAA);
      check("full_vpulses",   64'(vcount - v0), 64'd1);
      check("full_frame_err", 64'(bus.frame_err), 64'h0);
      check("full_proto_err", 64'(bus.proto_err), 64'h0);
      check("full_nbits_post", 64'(bus.nbits_rx), 64'h0);

      // Short 10-bit frame
      send_word(64'h2CE, 10);
      sh = {sh[53:0], 10'b1011001110};
      load_pulse();
      check("short_data_out",  bus.data_out, 64'hAAAAAAAAAAAAAACE);
      check("short_model",     bus.data_out, sh);
      check("short_frame_err", 64'(bus.frame_err), 64'h1);
      sh = 64'hDEADBEEF01234567;
      send_word(sh, 64);
      load_pulse();
      check("refill_data_out",  bus.data_out, 64'hDEADBEEF01234567);
      check("refill_frame_err", 64'(bus.frame_err), 64'h0);

      // Phase overlap mid-frame
      send_word(64'h16, 5);
      check("ovl_nbits_pre", 64'(bus.nbits_rx), 64'd5);
      bus.scan_phi = 1'b1; bus.scan_phi_bar = 1'b1;
      tick(4);
      bus.scan_phi = 1'b0; bus.scan_phi_bar = 1'b0;
      tick(4);
      check("ovl_proto_err", 64'(bus.proto_err), 64'h1);
      check("ovl_nbits",     64'(bus.nbits_rx), 64'd5);
      send_word(64'h1, 2);
      check("ovl_sticky",    64'(bus.proto_err), 64'h1);
      check("ovl_nbits_7",   64'(bus.nbits_rx), 64'd7);
      sh = {sh[56:0], 5'b10110, 2'b01};
      load_pulse();
      check("ovl_load_proto", 64'(bus.proto_err), 64'h0);
      check("ovl_load_ferr",  64'(bus.frame_err), 64'h1);
      check("ovl_load_data",  bus.data_out, sh);

      // phi_bar with no captured bit
      bus.scan_phi_bar = 1'b1;
      tick(3);
      bus.scan_phi_bar = 1'b0;
      tick(3);
      check("orphan_proto", 64'(bus.proto_err), 64'h1);
      check("orphan_nbits", 64'(bus.nbits_rx), 64'h0);
      check("orphan_sdo",   64'(bus.scan_data_out), 64'(sh[63]));
      load_pulse();
      check("orphan_data",  bus.data_out, sh);

      // Deselected frame is ignored
      bus.scan_id = 1'b0;
      tick(4);
      prev = bus.data_out;
      v0 = vcount;
      send_word(64'h123456789ABCDEF0, 64);
      load_pulse();
      check("desel_data",   bus.data_out, sh);
      check("desel_vpulse", 64'(vcount - v0), 64'h0);
      check("desel_nbits",  64'(bus.nbits_rx), 64'h0);
      check("desel_sdo",    64'(bus.scan_data_out), 64'(sh[63]));
      bus.scan_id = 1'b1;
      tick(4);

      // Reset mid-frame
      send_word(64'h2AAAAAAA, 30);
      check("mid_nbits", 64'(bus.nbits_rx), 64'd30);
      reset = 1'b1;
      #1;
      check("mrst_data_out",  bus.data_out, 64'h0);
      check("mrst_nbits",     64'(bus.nbits_rx), 64'h0);
      check("mrst_frame_err", 64'(bus.frame_err), 64'h0);
      check("mrst_proto_err", 64'(bus.proto_err), 64'h0);
      check("mrst_sdo",       64'(bus.scan_data_out), 64'h0);
      tick(2);
      reset = 1'b0;
      tick(4);
      sh = 64'h0123456789ABCDEF;
      send_word(sh, 64);
      load_pulse();
      check("post_rst_data", bus.data_out, 64'h0123456789ABCDEF);
      check("post_rst_ferr", 64'(bus.frame_err), 64'h0);

      // Ones then zeros through scan_data_out, count saturation
      sh = '1;
      send_word(sh, 64);
      check("ones_sdo",   64'(bus.scan_data_out), 64'h1);
      check("ones_nbits", 64'(bus.nbits_rx), 64'd64);
      for (int k = 1; k <= 64; k++) begin
         send_bit(1'b0);
         sh = {sh[62:0], 1'b0};
         check($sformatf("drain_sdo_%0d", k), 64'(bus.scan_data_out), (k < 64) ? 64'h1 : 64'h0);
      end
      check("sat_nbits_128", 64'(bus.nbits_rx), 64'd127);
      for (int k = 0; k < 72; k++) begin
         send_bit(k[0]);
         sh = {sh[62:0], k[0]};
      end
      check("sat_nbits_200", 64'(bus.nbits_rx), 64'd127);
      load_pulse();
      check("sat_data",  bus.data_out, sh);
      check("sat_ferr",  64'(bus.frame_err), 64'h1);
      check("sat_nbits_clr", 64'(bus.nbits_rx), 64'h0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
